sl_receiver: RTL

Decodes the two-wire SL line pair (SL0/SL1) produced by the SL transmitter into parallel data words. It synchronises and glitch-filters both lines, then tracks the symbol / gap / stop framing. It collects LSB-first data bits, checks parity and framing, and presents each received word to the bus-side master with a one-cycle valid strobe. The block is self-timed from line edges, so no rate configuration is needed for transmitter dividers 2..32 clk per phase.

---
 rtl/sl_pkg.sv | 33 +++
 rtl/sl_receiver_if.sv | 21 ++
 rtl/sl_rx_filter.sv | 46 ++++
 rtl/sl_receiver.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sl_pkg.sv
// rtl/sl_pkg.sv - line codes, FSM states and word-length limits for the SL receiver
package sl_pkg;

  localparam logic [1:0] SL_IDLE = 2'b11;
  localparam logic [1:0] SL_ONE  = 2'b10;
  localparam logic [1:0] SL_ZERO = 2'b01;
  localparam logic [1:0] SL_STOP = 2'b00;

  localparam int SL_QTY_MIN = 8;
  localparam int SL_QTY_MAX = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYMBOL,
    ST_GAP,
    ST_STOP,
    ST_WAIT_IDLE
  } sl_state_t;

  // Force a configured bit count into the legal even range 8..32.
  function automatic logic [5:0] sl_clamp_qty(input logic [5:0] qty);
    logic [5:0] res;
    if (qty < 6'(SL_QTY_MIN)) begin
      res = 6'(SL_QTY_MIN);
    end else if (qty > 6'(SL_QTY_MAX)) begin
      res = 6'(SL_QTY_MAX);
    end else begin
      res = {qty[5:1], 1'b0};
    end
    return res;
  endfunction

endpackage

// File: rtl/sl_receiver_if.sv
// rtl/sl_receiver_if.sv - bus-side control inputs and word delivery of the SL receiver
interface sl_receiver_if;
  logic        rx_en;
  logic [5:0]  cfg_bit_qty;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_parity_err;
  logic        rx_frame_err;
  logic        rx_busy;
  logic        status_changed;

  modport master (
    input  rx_en, cfg_bit_qty,
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy, status_changed
  );

  modport slave (
    output rx_en, cfg_bit_qty,
    input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy, status_changed
  );
endinterface

// File: rtl/sl_rx_filter.sv
// rtl/sl_rx_filter.sv - synchroniser and glitch filter for the two SL lines
module sl_rx_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] line_raw,
  output logic [1:0] line_filt
);

  localparam int RW = $clog2(GLITCH_CYCLES + 1) + 1;

  logic [1:0]    sync_q [SYNC_STAGES];
  logic [1:0]    sync_out;
  logic [1:0]    sync_prev;
  logic [RW-1:0] run_q;
  logic [RW-1:0] run_next;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Run length of the synchronised pair including this sample, saturating at GLITCH_CYCLES.
  always_comb begin
    run_next = RW'(1);
    if (sync_out == sync_prev) begin
      run_next = (run_q >= RW'(GLITCH_CYCLES)) ? RW'(GLITCH_CYCLES) : run_q + RW'(1);
    end
  end

  // Synchroniser chain; the filtered pair follows once the run is long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b11;
      sync_prev <= 2'b11;
      run_q     <= '0;
      line_filt <= 2'b11;
    end else begin
      sync_q[0] <= line_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_prev <= sync_out;
      run_q     <= run_next;
      if (run_next >= RW'(GLITCH_CYCLES)) line_filt <= sync_out;
    end
  end

endmodule

// File: rtl/sl_receiver.sv
// rtl/sl_receiver.sv - SL two-wire line decoder producing parallel words
module sl_receiver
  import sl_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int GLITCH_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sl0,
  input  logic          sl1,
  sl_receiver_if.master bus
);

  localparam int PW = $clog2(TIMEOUT_CYCLES + 1);

  sl_state_t     state, state_n;
  logic [1:0]    line, line_q, sym, sym_n;
  logic [5:0]    qty, qty_n, cnt, cnt_n;
  logic [31:0]   shreg, shreg_n, data_n;
  logic          par_bit, par_bit_n;
  logic          busy_n, valid_n, perr_n, ferr_n;
  logic [PW-1:0] phase;
  logic          line_chg, timeout, is_sym;

  sl_rx_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .GLITCH_CYCLES(GLITCH_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_raw ({sl0, sl1}),
    .line_filt(line)
  );

  assign line_chg = (line != line_q);
  assign timeout  = !line_chg && (phase == PW'(TIMEOUT_CYCLES - 1));
  assign is_sym   = (line == SL_ONE) || (line == SL_ZERO);

  // Framing FSM: next state, word assembly and output strobes.
  always_comb begin
    state_n   = state;
    qty_n     = qty;
    cnt_n     = cnt;
    shreg_n   = shreg;
    sym_n     = sym;
    par_bit_n = par_bit;
    busy_n    = bus.rx_busy;
    data_n    = bus.rx_data;
    perr_n    = bus.rx_parity_err;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.rx_en) begin
          if (is_sym) begin
            state_n = ST_SYMBOL;
            qty_n   = sl_clamp_qty(bus.cfg_bit_qty);
            cnt_n   = '0;
            shreg_n = '0;
            sym_n   = line;
            busy_n  = 1'b1;
          end else if (line == SL_STOP) begin
            ferr_n  = 1'b1;
            state_n = ST_WAIT_IDLE;
          end
        end
      end
      ST_SYMBOL: begin
        if (line == SL_IDLE) begin
          if (cnt < qty) shreg_n[cnt[4:0]] = (sym == SL_ONE);
          else           par_bit_n = (sym == SL_ONE);
          cnt_n   = cnt + 6'd1;
          state_n = ST_GAP;
        end else if (line != sym) begin
          ferr_n  = 1'b1;
          state_n = ST_WAIT_IDLE;
        end else if (timeout) begin
          ferr_n  = 1'b1;
          state_n = ST_WAIT_IDLE;
        end
      end
      ST_GAP: begin
        if (is_sym) begin
          if (cnt <= qty) begin
            state_n = ST_SYMBOL;
            sym_n   = line;
          end else begin
            ferr_n  = 1'b1;
            state_n = ST_WAIT_IDLE;
          end
        end else if (line == SL_STOP) begin
          if (cnt == qty + 6'd1) begin
            state_n = ST_STOP;
          end else begin
            ferr_n  = 1'b1;
            state_n = ST_WAIT_IDLE;
          end
        end else if (timeout) begin
          ferr_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end
      end
      ST_STOP: begin
        if (line == SL_IDLE) begin
          valid_n = 1'b1;
          data_n  = shreg;
          perr_n  = ~((^shreg) ^ par_bit);
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end else if (is_sym || timeout) begin
          ferr_n  = 1'b1;
          state_n = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (line == SL_IDLE) begin
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, word registers, phase timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= ST_IDLE;
      line_q                 <= SL_IDLE;
      sym                    <= SL_IDLE;
      qty                    <= 6'(SL_QTY_MIN);
      cnt                    <= '0;
      shreg                  <= '0;
      par_bit                <= 1'b0;
      phase                  <= '0;
      bus.rx_data            <= '0;
      bus.rx_valid           <= 1'b0;
      bus.rx_parity_err      <= 1'b0;
      bus.rx_frame_err       <= 1'b0;
      bus.rx_busy            <= 1'b0;
      bus.status_changed     <= 1'b0;
    end else begin
      state                  <= state_n;
      line_q                 <= line;
      sym                    <= sym_n;
      qty                    <= qty_n;
      cnt                    <= cnt_n;
      shreg                  <= shreg_n;
      par_bit                <= par_bit_n;
      if (line_chg)                              phase <= '0;
      else if (phase != PW'(TIMEOUT_CYCLES - 1)) phase <= phase + PW'(1);
      bus.rx_data            <= data_n;
      bus.rx_valid           <= valid_n;
      bus.rx_parity_err      <= perr_n;
      bus.rx_frame_err       <= ferr_n;
      bus.rx_busy            <= busy_n;
      bus.status_changed     <= (busy_n != bus.rx_busy);
    end
  end

endmodule
